// File: rtl/mem_burst_initiator.sv
// rtl/mem_burst_initiator.sv - burst initiator driving a 1-cycle registered-output slave memory port
// Optional feature macro: MEM_BOUNDARY_CHECK_EN (reject bursts whose last beat reaches MEM_SIZE)
module mem_burst_initiator #(
  parameter int ADDR_WIDTH = 12,
  parameter int DATA_WIDTH = 8,
  parameter int LEN_WIDTH  = 8,
  parameter int MEM_SIZE   = 4096
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_write,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [LEN_WIDTH-1:0]  req_len,
  input  logic                  wr_valid,
  input  logic [DATA_WIDTH-1:0] wr_data,
  output logic                  wr_ready,
  output logic                  rd_valid,
  output logic [DATA_WIDTH-1:0] rd_data,
  input  logic                  rd_ready,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic                  mem_wen,
  output logic                  mem_ren,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  output logic                  busy,
  output logic                  done,
  output logic                  err
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_WRITE = 2'd1,
    S_READ  = 2'd2,
    S_DRAIN = 2'd3
  } state_e;

`ifdef MEM_BOUNDARY_CHECK_EN
  localparam bit BOUNDARY_CHECK = 1'b1;
`else
  localparam bit BOUNDARY_CHECK = 1'b0;
`endif

  // Last-beat address is compared one bit wider so a wrapping burst is still caught.
  localparam logic [ADDR_WIDTH:0] MEM_LIMIT = (ADDR_WIDTH+1)'(MEM_SIZE);

  state_e                 state_q, state_d;
  logic [ADDR_WIDTH-1:0]  addr_cnt_q, addr_cnt_d;
  logic [LEN_WIDTH-1:0]   remaining_q, remaining_d;
  logic                   inflight_q, inflight_d;
  logic                   done_q, done_d;
  logic                   err_q, err_d;

  // Two-entry read buffer: head pointer plus occupancy 0..2.
  logic [DATA_WIDTH-1:0]  buf_q [2];
  logic                   head_q, head_d;
  logic [1:0]             occ_q, occ_d;

  logic                   push;
  logic                   pop;
  logic                   tail_idx;
  logic [1:0]             held_after_pop;
  logic                   accept;
  logic [ADDR_WIDTH:0]    end_addr;
  logic                   out_of_range;

  assign req_ready = (state_q == S_IDLE);
  assign wr_ready  = (state_q == S_WRITE);
  assign busy      = (state_q != S_IDLE);
  assign done      = done_q;
  assign err       = err_q;
  assign mem_addr  = addr_cnt_q;
  assign mem_wdata = wr_data;
  assign rd_valid  = (occ_q != 2'd0);
  assign rd_data   = buf_q[head_q];

  assign accept       = req_valid && req_ready;
  assign end_addr     = {1'b0, req_addr} + (ADDR_WIDTH+1)'(req_len);
  assign out_of_range = BOUNDARY_CHECK && (end_addr >= MEM_LIMIT);

  // Data returned by last cycle's read lands in the buffer this cycle.
  assign push = inflight_q;
  assign pop  = rd_valid && rd_ready;
  // With occ==2 no read can be in flight, so the tail is head (occ 0) or the other slot (occ 1).
  assign tail_idx       = head_q ^ occ_q[0];
  // Beats already owed to the buffer once this cycle's pop is taken.
  assign held_after_pop = occ_q + {1'b0, inflight_q} - {1'b0, pop};
  assign occ_d          = occ_q + {1'b0, push} - {1'b0, pop};
  assign head_d         = head_q ^ pop;

  // Next-state, counters and memory strobes.
  always_comb begin
    state_d     = state_q;
    addr_cnt_d  = addr_cnt_q;
    remaining_d = remaining_q;
    inflight_d  = 1'b0;
    done_d      = 1'b0;
    err_d       = 1'b0;
    mem_wen     = 1'b0;
    mem_ren     = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          if (out_of_range) begin
            err_d = 1'b1;
          end else begin
            addr_cnt_d  = req_addr;
            remaining_d = req_len;
            state_d     = req_write ? S_WRITE : S_READ;
          end
        end
      end
      S_WRITE: begin
        mem_wen = wr_valid;
        if (wr_valid) begin
          addr_cnt_d  = addr_cnt_q + ADDR_WIDTH'(1);
          remaining_d = remaining_q - LEN_WIDTH'(1);
          if (remaining_q == '0) begin
            state_d = S_IDLE;
            done_d  = 1'b1;
          end
        end
      end
      S_READ: begin
        mem_ren    = (held_after_pop < 2'd2);
        inflight_d = mem_ren;
        if (mem_ren) begin
          addr_cnt_d  = addr_cnt_q + ADDR_WIDTH'(1);
          remaining_d = remaining_q - LEN_WIDTH'(1);
          if (remaining_q == '0) begin
            state_d = S_DRAIN;
          end
        end
      end
      S_DRAIN: begin
        // Leave on the cycle the last buffered beat is consumed.
        if (!inflight_q && ((occ_q - {1'b0, pop}) == 2'd0)) begin
          state_d = S_IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Burst counters, read bookkeeping and completion/error pulses.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      addr_cnt_q  <= '0;
      remaining_q <= '0;
      inflight_q  <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      head_q      <= 1'b0;
      occ_q       <= 2'd0;
    end else begin
      addr_cnt_q  <= addr_cnt_d;
      remaining_q <= remaining_d;
      inflight_q  <= inflight_d;
      done_q      <= done_d;
      err_q       <= err_d;
      head_q      <= head_d;
      occ_q       <= occ_d;
    end
  end

  // Read buffer storage; the tail slot captures returning memory data.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      buf_q[0] <= '0;
      buf_q[1] <= '0;
    end else if (push) begin
      buf_q[tail_idx] <= mem_rdata;
    end
  end

endmodule

// File: tb/tb_mem_burst_initiator.sv
// tb/tb_mem_burst_initiator.sv - scoreboard bench for mem_burst_initiator
module tb_mem_burst_initiator;

  localparam int AW = 12;
  localparam int DW = 8;
  localparam int LW = 8;

  logic          clk = 1'b0;
  logic          rstn = 1'b0;
  logic          req_valid, req_ready, req_write;
  logic [AW-1:0] req_addr;
  logic [LW-1:0] req_len;
  logic          wr_valid, wr_ready;
  logic [DW-1:0] wr_data;
  logic          rd_valid, rd_ready;
  logic [DW-1:0] rd_data;
  logic [AW-1:0] mem_addr;
  logic          mem_wen, mem_ren;
  logic [DW-1:0] mem_wdata, mem_rdata;
  logic          busy, done, err;

  logic [DW-1:0]    mem     [0:4095];
  logic [DW-1:0]    exp_mem [0:4095];
  logic [AW+DW-1:0] wq[$];
  logic [DW-1:0]    rq[$];
  int checks = 0;
  int errors = 0;

  mem_burst_initiator dut (
    .clk(clk), .rstn(rstn),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_len(req_len),
    .wr_valid(wr_valid), .wr_data(wr_data), .wr_ready(wr_ready),
    .rd_valid(rd_valid), .rd_data(rd_data), .rd_ready(rd_ready),
    .mem_addr(mem_addr), .mem_wen(mem_wen), .mem_ren(mem_ren),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  // Slave memory: synchronous write, registered read output.
  always @(posedge clk) begin
    if (mem_wen) mem[mem_addr] <= mem_wdata;
    if (mem_ren) mem_rdata <= mem[mem_addr];
  end

  initial begin
    #500000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1);
  end

  task automatic do_write(input logic [AW-1:0] addr, input logic [LW-1:0] len,
                          input logic [DW-1:0] d0, input logic [4:0] pat, input bit gapped);
    int beats, sent, cyc, dones, last_cyc, done_cyc, seen;
    bit in_write;
    logic [AW-1:0] a;
    logic [AW+DW-1:0] e;
    beats = int'(len) + 1; sent = 0; cyc = 0; dones = 0; last_cyc = -1; done_cyc = -1; seen = 0;
    @(posedge clk); #1;
    req_valid = 1'b1; req_write = 1'b1; req_addr = addr; req_len = len; wr_valid = 1'b0;
    @(negedge clk);
    checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL wr_req_ready got %b exp 1", req_ready); end
    @(posedge clk); #1;
    req_valid = 1'b0;
    while (dones == 0 && cyc < 5*beats + 20) begin
      cyc++;
      in_write = (sent < beats);
      if (in_write && (!gapped || pat[(cyc-1)%5])) begin
        a = addr + AW'(sent);
        wr_valid = 1'b1; wr_data = d0 + DW'(sent);
        wq.push_back({a, wr_data});
        exp_mem[a] = wr_data;
        sent++;
        if (sent == beats) last_cyc = cyc;
      end else begin
        wr_valid = 1'b0;
      end
      @(negedge clk);
      checks++; if (mem_wen !== wr_valid) begin errors++; $display("FAIL wr_mem_wen cyc %0d got %b exp %b", cyc, mem_wen, wr_valid); end
      checks++; if (wr_ready !== in_write) begin errors++; $display("FAIL wr_ready cyc %0d got %b exp %b", cyc, wr_ready, in_write); end
      checks++; if (busy !== in_write) begin errors++; $display("FAIL wr_busy cyc %0d got %b exp %b", cyc, busy, in_write); end
      checks++; if ({mem_ren, err} !== 2'b00) begin errors++; $display("FAIL wr_ren_err cyc %0d got %b%b exp 00", cyc, mem_ren, err); end
      if (mem_wen === 1'b1) begin
        checks++;
        if (wq.size() == 0) begin
          errors++; $display("FAIL wr_extra_write addr %h data %h exp none", mem_addr, mem_wdata);
        end else begin
          e = wq.pop_front();
          if ({mem_addr, mem_wdata} !== e) begin errors++; $display("FAIL wr_beat got %h/%h exp %h/%h", mem_addr, mem_wdata, e[AW+DW-1:DW], e[DW-1:0]); end
          seen++;
        end
      end
      if (done === 1'b1) begin
        dones++; done_cyc = cyc;
        checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL wr_done_req_ready got %b exp 1", req_ready); end
      end
      @(posedge clk); #1;
      wr_valid = 1'b0;
    end
    checks++; if (dones != 1) begin errors++; $display("FAIL wr_done_count got %0d exp 1", dones); end
    checks++; if (done_cyc != last_cyc + 1) begin errors++; $display("FAIL wr_done_cycle got %0d exp %0d", done_cyc, last_cyc + 1); end
    checks++; if (seen != beats || wq.size() != 0) begin errors++; $display("FAIL wr_beats got %0d exp %0d", seen, beats); end
    wq.delete();
    @(negedge clk);
    checks++; if ({done, busy} !== 2'b00) begin errors++; $display("FAIL wr_after got %b%b exp 00", done, busy); end
  endtask

  task automatic do_read(input logic [AW-1:0] addr, input logic [LW-1:0] len, input logic [3:0] pat,
                         input bit stalled, input bit timing, input int abort_after);
    int beats, cyc, issued, popped, dones, first_valid, done_cyc;
    bit pop_now, exp_ren;
    logic [DW-1:0] e;
    beats = int'(len) + 1; cyc = 0; issued = 0; popped = 0; dones = 0; first_valid = -1; done_cyc = -1;
    @(posedge clk); #1;
    req_valid = 1'b1; req_write = 1'b0; req_addr = addr; req_len = len;
    for (int i = 0; i < beats; i++) rq.push_back(exp_mem[addr + AW'(i)]);
    @(negedge clk);
    checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL rd_req_ready got %b exp 1", req_ready); end
    @(posedge clk); #1;
    req_valid = 1'b0;
    while (dones == 0 && cyc < 8*beats + 20) begin
      cyc++;
      rd_ready = stalled ? pat[(cyc-1)%4] : 1'b1;
      @(negedge clk);
      pop_now = (rd_valid === 1'b1) && rd_ready;
      exp_ren = (issued < beats) && ((issued - popped - int'(pop_now)) < 2);
      checks++; if (mem_ren !== exp_ren) begin errors++; $display("FAIL rd_mem_ren cyc %0d got %b exp %b", cyc, mem_ren, exp_ren); end
      checks++; if (mem_wen !== 1'b0) begin errors++; $display("FAIL rd_mem_wen cyc %0d got %b exp 0", cyc, mem_wen); end
      if (mem_ren === 1'b1) begin
        checks++; if (mem_addr !== addr + AW'(issued)) begin errors++; $display("FAIL rd_mem_addr got %h exp %h", mem_addr, addr + AW'(issued)); end
        issued++;
      end
      if (rd_valid === 1'b1 && first_valid < 0) first_valid = cyc;
      if (pop_now) begin
        checks++;
        if (rq.size() == 0) begin
          errors++; $display("FAIL rd_extra_beat got %h exp none", rd_data);
        end else begin
          e = rq.pop_front();
          if (rd_data !== e) begin errors++; $display("FAIL rd_data beat %0d got %h exp %h", popped, rd_data, e); end
        end
        popped++;
      end
      if (done === 1'b1) begin dones++; done_cyc = cyc; end
      if (abort_after >= 0 && popped == abort_after) return;
      @(posedge clk); #1;
    end
    rd_ready = 1'b1;
    checks++; if (dones != 1) begin errors++; $display("FAIL rd_done_count got %0d exp 1", dones); end
    checks++; if (popped != beats || rq.size() != 0) begin errors++; $display("FAIL rd_beats got %0d exp %0d", popped, beats); end
    if (timing) begin
      // rd_valid first appears two edges after the accepting edge, then one beat per cycle.
      checks++; if (first_valid != 3) begin errors++; $display("FAIL rd_latency got %0d exp 3", first_valid); end
      checks++; if (done_cyc != beats + 3) begin errors++; $display("FAIL rd_done_cycle got %0d exp %0d", done_cyc, beats + 3); end
    end
    rq.delete();
    @(negedge clk);
    checks++; if ({done, busy} !== 2'b00) begin errors++; $display("FAIL rd_after got %b%b exp 00", done, busy); end
  endtask

  task automatic test_reset();
    rstn = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL rst_req_ready got %b exp 1", req_ready); end
    checks++; if ({busy, done, err, wr_ready, rd_valid} !== 5'b0) begin errors++; $display("FAIL rst_status got %b exp 00000", {busy, done, err, wr_ready, rd_valid}); end
    checks++; if ({mem_wen, mem_ren} !== 2'b00) begin errors++; $display("FAIL rst_strobes got %b exp 00", {mem_wen, mem_ren}); end
    checks++; if (mem_addr !== '0) begin errors++; $display("FAIL rst_mem_addr got %h exp 000", mem_addr); end
    rstn = 1'b1;
  endtask

  task automatic test_write_burst();
    do_write(12'h010, 8'd3, 8'hA0, 5'b0, 1'b0);
  endtask

  task automatic test_read_burst();
    do_read(12'h010, 8'd3, 4'hF, 1'b0, 1'b1, -1);
  endtask

  task automatic test_read_backpressure();
    logic [DW-1:0] b;
    b = DW'($urandom_range(255));
    do_write(12'h300, 8'd7, b, 5'b0, 1'b0);
    do_read(12'h300, 8'd7, 4'b1001, 1'b1, 1'b0, -1);
  endtask

  task automatic test_wrap();
`ifdef MEM_BOUNDARY_CHECK_EN
    @(posedge clk); #1;
    req_valid = 1'b1; req_write = 1'b1; req_addr = 12'hFFE; req_len = 8'd3; wr_valid = 1'b0;
    @(negedge clk);
    checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL oob_req_ready got %b exp 1", req_ready); end
    @(posedge clk); #1;
    req_valid = 1'b0; wr_valid = 1'b1; wr_data = 8'hC0;
    @(negedge clk);
    checks++; if (err !== 1'b1) begin errors++; $display("FAIL oob_err got %b exp 1", err); end
    checks++; if ({mem_wen, busy, done} !== 3'b000) begin errors++; $display("FAIL oob_quiet got %b exp 000", {mem_wen, busy, done}); end
    @(posedge clk); #1;
    @(negedge clk);
    checks++; if ({err, mem_wen, busy} !== 3'b000) begin errors++; $display("FAIL oob_after got %b exp 000", {err, mem_wen, busy}); end
    wr_valid = 1'b0;
`else
    do_write(12'hFFE, 8'd3, 8'hC0, 5'b0, 1'b0);
    do_read(12'hFFE, 8'd3, 4'hF, 1'b0, 1'b1, -1);
`endif
  endtask

  task automatic test_write_gapped();
    do_write(12'h040, 8'd2, 8'h70, 5'b11001, 1'b1);
    do_read(12'h040, 8'd2, 4'hF, 1'b0, 1'b1, -1);
  endtask

  task automatic test_long_burst();
    do_write(12'h100, 8'hFF, 8'h00, 5'b0, 1'b0);
    do_read(12'h1F8, 8'd7, 4'b1001, 1'b1, 1'b0, -1);
  endtask

  task automatic test_reset_mid_burst();
    do_write(12'h020, 8'd0, 8'h5A, 5'b0, 1'b0);
    do_read(12'h010, 8'd3, 4'hF, 1'b0, 1'b0, 2);
    @(posedge clk); #1;
    rstn = 1'b0;
    #1;
    checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL mid_rst_req_ready got %b exp 1", req_ready); end
    checks++; if ({busy, done, err, wr_ready, rd_valid} !== 5'b0) begin errors++; $display("FAIL mid_rst_status got %b exp 00000", {busy, done, err, wr_ready, rd_valid}); end
    checks++; if ({mem_wen, mem_ren} !== 2'b00 || mem_addr !== '0) begin errors++; $display("FAIL mid_rst_mem got %b %h exp 00 000", {mem_wen, mem_ren}, mem_addr); end
    rq.delete();
    rd_ready = 1'b1;
    @(negedge clk);
    rstn = 1'b1;
    do_read(12'h020, 8'd0, 4'hF, 1'b0, 1'b1, -1);
  endtask

  initial begin
    req_valid = 1'b0; req_write = 1'b0; req_addr = '0; req_len = '0;
    wr_valid = 1'b0; wr_data = '0; rd_ready = 1'b1;
    test_reset();
    test_write_burst();
    test_read_burst();
    test_read_backpressure();
    test_wrap();
    test_write_gapped();
    test_long_burst();
    test_reset_mid_burst();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_burst_initiator.md
Name: mem_burst_initiator

Overview:
- Initiator (master) side of the slave memory port (addr/wen/ren/wdata/rdata).
- Accepts single or burst requests from a bus-side slave controller over a valid/ready handshake.
- Writes: streams wr_data beats into memory.
- Reads: issues reads against the 1-cycle registered-output BRAM and returns data on a back-pressurable stream, at full rate when unstalled.

Parameters:
- ADDR_WIDTH, 12, memory address width; burst addresses wrap modulo 2^ADDR_WIDTH.
- DATA_WIDTH, 8, data beat width.
- LEN_WIDTH, 8, burst length field width; beats = req_len+1.
- MEM_SIZE, 4096, memory depth in words; used only by the optional feature.

Ports:
- clk  in  1  system clock.
- rstn  in  1  reset, asynchronous, active-low.
- req_valid  in  1  request valid.
- req_ready  out  1  request accepted when both high; equals (state==IDLE).
- req_write  in  1  1 = write burst, 0 = read burst.
- req_addr  in  ADDR_WIDTH  burst start address.
- req_len  in  LEN_WIDTH  beats minus one.
- wr_valid  in  1  write beat valid.
- wr_data  in  DATA_WIDTH  write beat data.
- wr_ready  out  1  write beat accepted; equals (state==WRITE).
- rd_valid  out  1  read beat valid.
- rd_data  out  DATA_WIDTH  read beat data.
- rd_ready  in  1  read beat consumed.
- mem_addr  out  ADDR_WIDTH  to slave memory addr.
- mem_wen  out  1  to slave memory wen.
- mem_ren  out  1  to slave memory ren.
- mem_wdata  out  DATA_WIDTH  to slave memory wdata.
- mem_rdata  in  DATA_WIDTH  from slave memory rdata; valid the cycle after mem_ren.
- busy  out  1  high whenever state != IDLE.
- done  out  1  one-cycle pulse at burst completion.
- err  out  1  one-cycle pulse on rejected request (optional feature only).

Behaviour:
- Clocking/reset: one clock (clk); rstn asynchronous, active-low.
- Reset values:
  - state=IDLE; addr counter, beat counter, inflight flag, 2-entry read buffer all cleared.
  - mem_wen=mem_ren=0, mem_addr=0, rd_valid=0, done=0, err=0, busy=0, wr_ready=0.
  - req_ready=1 (combinational from IDLE).
- Reset mid-burst: burst abandoned, buffer flushed, no done; in-flight mem_rdata discarded.
- States: IDLE, WRITE, READ, DRAIN.
- IDLE:
  - On req_valid&req_ready: addr_cnt<=req_addr, remaining<=req_len.
  - Go to WRITE if req_write, else READ.
- WRITE:
  - mem_wen = wr_valid (combinational); mem_wdata=wr_data; mem_addr=addr_cnt.
  - Each accepted beat: addr_cnt+1 (wraps at 2^ADDR_WIDTH), remaining-1.
  - Beat accepted with remaining==0: next state IDLE, done pulses in that first IDLE cycle.
  - wr_valid low: no write, state holds indefinitely.
- READ:
  - mem_ren = (occ + inflight - pop) < 2, where occ = buffer occupancy 0..2, pop = rd_valid&rd_ready.
  - Each issue: addr_cnt+1, remaining-1; inflight<=mem_ren.
  - When inflight==1, mem_rdata is written into buffer tail that cycle.
  - Buffer is never overrun.
  - Issue with remaining==0 -> DRAIN.
- DRAIN: no memory access; when inflight==0 and occ==0 (after final pop) -> IDLE, done pulses in the first IDLE cycle.
- Read stream:
  - rd_valid = occ!=0; rd_data = buffer head; FIFO order preserved.
  - Simultaneous push and pop supported.
  - With rd_ready held high: first rd_valid 2 cycles after request acceptance, then 1 beat/cycle.
- mem_wen and mem_ren are never high together. Outside WRITE/READ both are 0; mem_addr shows addr_cnt.
- New request may be accepted in the same cycle done pulses.
- req_len = all-ones gives 2^LEN_WIDTH beats; the counter must not wrap early.

Optional Feature:
- Macro: MEM_BOUNDARY_CHECK_EN.
- Defined:
  - In IDLE, a request with req_addr + req_len >= MEM_SIZE (computed at ADDR_WIDTH+1 bits) is still handshaken (req_ready=1).
  - No memory access, state stays IDLE, err pulses 1 cycle later, no done.
- Not defined: err tied 0; bursts wrap modulo 2^ADDR_WIDTH.

Test Plan:
- Write burst addr=0x010, len=3, data A0..A3, wr_valid continuous -> mem_wen 4 consecutive cycles, mem_addr 0x010..0x013, done 1 cycle after last beat; busy high 4 cycles.
- Read burst addr=0x010, len=3, rd_ready=1 (memory model preloaded A0..A3) -> rd_data A0,A1,A2,A3 on consecutive cycles, first 2 cycles after acceptance, done once.
- Read len=7 with rd_ready toggling 1,0,0,1,...:
  - All 8 beats arrive in order, none lost or duplicated.
  - mem_ren drops when occ+inflight-pop reaches 2.
- Wrap: write addr=0xFFE, len=3 -> mem_addr 0xFFE,0xFFF,0x000,0x001; with MEM_BOUNDARY_CHECK_EN the request instead yields err pulse and zero mem_wen.
- Write burst len=2 with wr_valid gapped 1,0,0,1,1 -> exactly 3 writes, only in wr_valid cycles.
- rstn low after 2 of 4 read beats -> all outputs at reset values immediately; after release, new read addr=0x020, len=0 completes normally with single done.
